// File: rtl/sdram_arb_pkg.sv
// Shared types, widths and the round-robin pick helper
// for the SDRAM command arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W      = 26;
  localparam int DATA_W      = 16;
  localparam int BURST_WORDS = 8;
  localparam int BEAT_W      = $clog2(BURST_WORDS);
  localparam int MAX_PORTS   = 8;

  typedef struct packed {
    logic        chip;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
  } sdram_addr_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_t;

  // One-hot grant: first set bit of req at or above ptr,
  // wrapping at n-1 back to 0.
  function automatic logic [MAX_PORTS-1:0] rr_pick(
    input logic [MAX_PORTS-1:0] req,
    input logic [2:0]           ptr,
    input logic [3:0]           n
  );
    logic [MAX_PORTS-1:0] gnt;
    logic [3:0]           idx;
    logic                 found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n)
        idx = idx - n;
      if (!found && (4'(k) < n) && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO holding the owning port of each outstanding
// read burst, oldest at head.
module sdram_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_tag,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin SDRAM command arbiter with read-burst steering.
// Define SDRAM_ARB_PRIO0_EN to give port 0 fixed top priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ack,
  output logic [DATA_W-1:0]           rd_data,
  output logic [NUM_PORTS-1:0]        rd_val,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_cmd_ready,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_rdata_val,
  output logic                        err_orphan
);

  localparam int PORT_W =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PORT_W-1:0]    rr_ptr;
  logic [PORT_W-1:0]    rr_next;
  logic [PORT_W-1:0]    gnt_idx;
  logic [PORT_W-1:0]    head;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] grant;
  logic [MAX_PORTS-1:0] elig_pad;
  logic [MAX_PORTS-1:0] pick;
  logic                 unused_pick;
  logic                 grant_valid;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 beat;
  logic                 owned;
  logic                 orphan;
  logic [BEAT_W-1:0]    beat_cnt;
  cmd_t                 cmd;
  sdram_addr_t          addr_sel;
  logic [DATA_W-1:0]    wdata_sel;

  // Reset gates eligibility so every output drops at once.
  assign elig = (req_read | req_write)
              & ~(req_read & {NUM_PORTS{full}})
              & {NUM_PORTS{~reset}};

  always_comb begin
    elig_pad = '0;
    elig_pad[NUM_PORTS-1:0] = elig;
`ifdef SDRAM_ARB_PRIO0_EN
    pick = '0;
    if (elig[0])
      pick[0] = 1'b1;
    else
      pick = rr_pick(
        elig_pad & {{(MAX_PORTS-1){1'b1}}, 1'b0},
        3'(rr_ptr), 4'(NUM_PORTS));
`else
    pick = rr_pick(elig_pad, 3'(rr_ptr), 4'(NUM_PORTS));
`endif
  end

  assign grant       = pick[NUM_PORTS-1:0];
  assign unused_pick = ^pick;
  assign grant_valid = |grant;
  assign accept      = grant_valid & mem_cmd_ready;
  assign req_ack     = grant & {NUM_PORTS{mem_cmd_ready}};

  always_comb begin
    gnt_idx   = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    cmd       = CMD_NONE;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        gnt_idx   = PORT_W'(i);
        addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
        wdata_sel = req_wdata[i*DATA_W +: DATA_W];
        cmd       = req_read[i] ? CMD_READ : CMD_WRITE;
      end
    end
  end

  assign mem_read  = (cmd == CMD_READ);
  assign mem_write = (cmd == CMD_WRITE);
  assign mem_addr  = addr_sel;
  assign mem_wdata = wdata_sel;
  assign push      = accept & mem_read;

  assign rr_next = (gnt_idx == PORT_W'(NUM_PORTS-1))
                 ? '0 : gnt_idx + 1'b1;

  assign beat   = mem_rdata_val & ~reset;
  assign owned  = beat & ~empty;
  assign orphan = beat & empty;
  assign pop    = owned
                & (beat_cnt == BEAT_W'(BURST_WORDS-1));

  assign rd_data = reset ? '0 : mem_rdata;

  always_comb begin
    rd_val = '0;
    if (owned)
      rd_val[head] = 1'b1;
  end

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (PORT_W)
  ) u_tags (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (gnt_idx),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      err_orphan <= 1'b0;
    end else begin
`ifdef SDRAM_ARB_PRIO0_EN
      if (accept && gnt_idx != '0)
        rr_ptr <= rr_next;
`else
      if (accept)
        rr_ptr <= rr_next;
`endif
      if (owned)
        beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
      if (orphan)
        err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios
// plus randomized traffic against a queue-based model.
module tb_sdram_arbiter;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int AW = 26;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   rd_data;
  logic [N-1:0]    rd_val;
  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_cmd_ready;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rdata_val;
  logic            err_orphan;

  int tests_run    = 0;
  int tests_failed = 0;

  int   m_ptr;
  int   m_q[$];
  int   m_beat;
  logic m_err;

  always #5 clk = ~clk;

  sdram_arbiter #(.NUM_PORTS(N), .TAG_DEPTH(TD)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_read      (req_read),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ack       (req_ack),
    .rd_data       (rd_data),
    .rd_val        (rd_val),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_rdata     (mem_rdata),
    .mem_rdata_val (mem_rdata_val),
    .err_orphan    (err_orphan)
  );

  task automatic idle();
    req_read      = '0;
    req_write     = '0;
    req_addr      = '0;
    req_wdata     = '0;
    mem_cmd_ready = 1'b0;
    mem_rdata     = '0;
    mem_rdata_val = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Model grant: first eligible port upward from the pointer.
  function automatic int m_pick(logic [N-1:0] el);
    int idx;
`ifdef SDRAM_ARB_PRIO0_EN
    if (el[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
`ifdef SDRAM_ARB_PRIO0_EN
      if (idx == 0) continue;
`endif
      if (el[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic test_reset();
    idle();
    reset         = 1'b1;
    req_write     = 4'b1111;
    req_read      = 4'b0001;
    mem_cmd_ready = 1'b1;
    mem_rdata_val = 1'b1;
    #3;
    tests_run++;
    if (req_ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ack: got %b want 0000", req_ack);
    end
    tests_run++;
    if ({mem_read, mem_write} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_cmd: got %b want 00",
               {mem_read, mem_write});
    end
    tests_run++;
    if (rd_val !== 4'b0000 || err_orphan !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ret: rd_val %b err %b want 0000 0",
               rd_val, err_orphan);
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr %h wdata %h want 0 0",
               mem_addr, mem_wdata);
    end
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    req_write[1]        = 1'b1;
    req_addr[1*AW +: AW] = 26'h0000123;
    req_wdata[1*DW +: DW] = 16'hBEEF;
    mem_cmd_ready       = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL single_ack: got %b want 0010", req_ack);
    end
    tests_run++;
    if ({mem_read, mem_write} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_cmd: got %b want 01",
               {mem_read, mem_write});
    end
    tests_run++;
    if (mem_addr !== 26'h0000123 || mem_wdata !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL single_bus: addr %h wdata %h want 0000123 beef",
               mem_addr, mem_wdata);
    end
    tick();
    req_write = 4'b1111;
    @(negedge clk);
    tests_run++;
    if (req_ack !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_ptr: got %b want 0100", req_ack);
    end
    tick();
    idle();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req_write = 4'b1111;
    for (int i = 0; i < N; i++)
      req_addr[i*AW +: AW] = AW'(32'h100 + i);
    mem_cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (req_ack !== seq[k]) begin
        tests_failed++;
        $display("FAIL rr_seq%0d: got %b want %b",
                 k, req_ack, seq[k]);
      end
      tick();
    end
    mem_cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (req_ack !== 4'b0000 || mem_addr !== 26'h101) begin
        tests_failed++;
        $display("FAIL rr_stall%0d: ack %b addr %h want 0000 101",
                 k, req_ack, mem_addr);
      end
      tick();
    end
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rr_frozen: got %b want 0010", req_ack);
    end
    tick();
    idle();
  endtask

  task automatic test_read_return();
    logic [N-1:0] want;
    do_reset();
    req_read[2]   = 1'b1;
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ack !== 4'b0100 || mem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_cmd2: ack %b rd %b want 0100 1",
               req_ack, mem_read);
    end
    tick();
    req_read = 4'b0001;
    @(negedge clk);
    tests_run++;
    if (req_ack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rd_cmd0: got %b want 0001", req_ack);
    end
    tick();
    idle();
    tick();
    for (int b = 0; b < 16; b++) begin
      mem_rdata_val = 1'b1;
      mem_rdata     = DW'(b);
      want          = (b < 8) ? 4'b0100 : 4'b0001;
      @(negedge clk);
      tests_run++;
      if (rd_val !== want || rd_data !== DW'(b)) begin
        tests_failed++;
        $display("FAIL rd_beat%0d: val %b data %h want %b %h",
                 b, rd_val, rd_data, want, b);
      end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (rd_val !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rd_extra: got %b want 0000", rd_val);
    end
    tick();
    mem_rdata_val = 1'b0;
    tests_run++;
    if (err_orphan !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_empty: err %b want 1", err_orphan);
    end
    idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    req_read[3]   = 1'b1;
    mem_cmd_ready = 1'b1;
    for (int k = 0; k < TD; k++) begin
      @(negedge clk);
      tests_run++;
      if (req_ack !== 4'b1000) begin
        tests_failed++;
        $display("FAIL full_fill%0d: got %b want 1000",
                 k, req_ack);
      end
      tick();
    end
    req_write[1] = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ack !== 4'b0010 || mem_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_write: ack %b wr %b want 0010 1",
               req_ack, mem_write);
    end
    tick();
    req_write = '0;
    for (int b = 0; b < 8; b++) begin
      mem_rdata_val = 1'b1;
      mem_rdata     = DW'(16'h5A00 + b);
      @(negedge clk);
      tests_run++;
      if (req_ack !== 4'b0000 || rd_val !== 4'b1000) begin
        tests_failed++;
        $display("FAIL full_hold%0d: ack %b val %b want 0000 1000",
                 b, req_ack, rd_val);
      end
      tick();
    end
    mem_rdata_val = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ack !== 4'b1000 || mem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_fifth: ack %b rd %b want 1000 1",
               req_ack, mem_read);
    end
    tick();
    idle();
  endtask

  task automatic test_orphan();
    do_reset();
    mem_rdata_val = 1'b1;
    mem_rdata     = 16'hAAAA;
    @(negedge clk);
    tests_run++;
    if (rd_val !== 4'b0000 || err_orphan !== 1'b0) begin
      tests_failed++;
      $display("FAIL orph_beat: val %b err %b want 0000 0",
               rd_val, err_orphan);
    end
    tick();
    mem_rdata_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (err_orphan !== 1'b1) begin
        tests_failed++;
        $display("FAIL orph_sticky%0d: got %b want 1",
                 k, err_orphan);
      end
      tick();
    end
    req_read[0]   = 1'b1;
    mem_cmd_ready = 1'b1;
    tick();
    req_read = '0;
    for (int b = 0; b < 3; b++) begin
      mem_rdata_val = 1'b1;
      tick();
    end
    req_write = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (req_ack !== '0 || rd_val !== '0 ||
        mem_read !== 1'b0 || mem_write !== 1'b0 ||
        err_orphan !== 1'b0 || rd_data !== '0) begin
      tests_failed++;
      $display("FAIL orph_async: ack %b val %b r %b w %b err %b d %h",
               req_ack, rd_val, mem_read, mem_write,
               err_orphan, rd_data);
    end
    req_write = '0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rd_val !== 4'b0000) begin
      tests_failed++;
      $display("FAIL orph_flush: got %b want 0000", rd_val);
    end
    tick();
    tests_run++;
    if (err_orphan !== 1'b1) begin
      tests_failed++;
      $display("FAIL orph_after: got %b want 1", err_orphan);
    end
    idle();
  endtask

  task automatic test_prio();
    logic [N-1:0] want;
    do_reset();
    req_write     = 4'b0101;
    mem_cmd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef SDRAM_ARB_PRIO0_EN
      want = 4'b0001;
`else
      want = (k % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
      @(negedge clk);
      tests_run++;
      if (req_ack !== want) begin
        tests_failed++;
        $display("FAIL prio%0d: got %b want %b",
                 k, req_ack, want);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_random(int cycles);
    logic [N-1:0]  el;
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  exp_val;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic          exp_r;
    logic          exp_w;
    logic          full;
    int            g;
    do_reset();
    m_ptr  = 0;
    m_q.delete();
    m_beat = 0;
    m_err  = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_read[i] && !req_write[i] &&
            $urandom_range(0, 2) == 0) begin
          req_read[i]  = 1'($urandom_range(0, 1));
          req_write[i] = ($urandom_range(0, 3) == 0)
                       || !req_read[i];
          req_addr[i*AW +: AW]  = AW'($urandom);
          req_wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      mem_cmd_ready = ($urandom_range(0, 3) != 0);
      mem_rdata_val = (m_q.size() > 0)
                    && ($urandom_range(0, 1) == 1);
      mem_rdata     = DW'($urandom);
      full = (m_q.size() == TD);
      el   = (req_read | req_write) & ~(req_read & {N{full}});
      g    = m_pick(el);
      exp_ack  = '0;
      exp_r    = 1'b0;
      exp_w    = 1'b0;
      exp_addr = '0;
      exp_wd   = '0;
      if (g >= 0) begin
        exp_r    = req_read[g];
        exp_w    = !req_read[g];
        exp_addr = req_addr[g*AW +: AW];
        exp_wd   = req_wdata[g*DW +: DW];
        if (mem_cmd_ready) exp_ack[g] = 1'b1;
      end
      exp_val = '0;
      if (mem_rdata_val && m_q.size() > 0)
        exp_val[m_q[0]] = 1'b1;
      @(negedge clk);
      tests_run++;
      if (req_ack !== exp_ack) begin
        tests_failed++;
        $display("FAIL rnd%0d_ack: got %b want %b",
                 c, req_ack, exp_ack);
      end
      tests_run++;
      if ({mem_read, mem_write} !== {exp_r, exp_w}) begin
        tests_failed++;
        $display("FAIL rnd%0d_cmd: got %b want %b",
                 c, {mem_read, mem_write}, {exp_r, exp_w});
      end
      tests_run++;
      if (mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
        tests_failed++;
        $display("FAIL rnd%0d_bus: %h %h want %h %h",
                 c, mem_addr, mem_wdata, exp_addr, exp_wd);
      end
      tests_run++;
      if (rd_val !== exp_val || rd_data !== mem_rdata) begin
        tests_failed++;
        $display("FAIL rnd%0d_ret: %b %h want %b %h",
                 c, rd_val, rd_data, exp_val, mem_rdata);
      end
      tests_run++;
      if (err_orphan !== m_err) begin
        tests_failed++;
        $display("FAIL rnd%0d_err: got %b want %b",
                 c, err_orphan, m_err);
      end
      if (mem_rdata_val) begin
        if (m_q.size() == 0) begin
          m_err = 1'b1;
        end else begin
          m_beat++;
          if (m_beat == 8) begin
            void'(m_q.pop_front());
            m_beat = 0;
          end
        end
      end
      if (g >= 0 && mem_cmd_ready) begin
        if (req_read[g]) m_q.push_back(g);
`ifdef SDRAM_ARB_PRIO0_EN
        if (g != 0) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end
      tick();
      if (g >= 0 && mem_cmd_ready) begin
        if (req_read[g]) req_read[g] = 1'b0;
        else             req_write[g] = 1'b0;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_return();
    test_fifo_full();
    test_orphan();
    test_prio();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Round-robin arbiter that shares the single-port SDRAM controller command interface between NUM_PORTS requesters (CPU, video, DMA, ...). It forwards one accepted read/write per cycle to the controller, tracks outstanding reads in a tag FIFO, and steers each 8-word read burst back to the requester that issued it. It sits between the SoC masters and the SDRAM controller.

Parameters:
NUM_PORTS, 4, number of requester ports (2..8)
TAG_DEPTH, 4, maximum outstanding read bursts (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_read  in  NUM_PORTS  per-port read request (level, held until acked)
req_write  in  NUM_PORTS  per-port write request (level, held until acked)
req_addr  in  NUM_PORTS*26  per-port {chip, bank[1:0], row[12:0], col[9:0]}
req_wdata  in  NUM_PORTS*16  per-port write word
req_ack  out  NUM_PORTS  one-hot, 1 = command accepted this cycle
rd_data  out  16  read word, broadcast to all ports
rd_val  out  NUM_PORTS  one-hot read-data valid for owning port
mem_read  out  1  to controller read
mem_write  out  1  to controller write
mem_addr  out  26  to controller addr
mem_wdata  out  16  to controller data_write
mem_cmd_ready  in  1  from controller cmd_ready
mem_rdata  in  16  from controller data_read
mem_rdata_val  in  1  from controller data_read_val
err_orphan  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, tag FIFO empty, beat_cnt=0, err_orphan=0; all req_ack/rd_val=0, mem_read/mem_write=0.
- Eligible port i: (req_read[i]|req_write[i]) and not (req_read[i] and tag FIFO full). If both bits set on one port, read wins; write stays pending.
- Grant: combinational, first eligible port searching upward from rr_ptr, wrapping at NUM_PORTS-1 -> 0.
- mem_read/mem_write/mem_addr/mem_wdata driven combinationally from the granted port; mem_addr/mem_wdata are 0 and mem_read/mem_write are 0 when there is no grant.
- Accept: req_ack[g] = grant_valid & mem_cmd_ready. A command is consumed on the rising edge where req_ack is 1. Zero-cycle added latency.
- On accept: rr_ptr <= (g+1) mod NUM_PORTS. rr_ptr does not move when there is no accept.
- Read accept pushes g into the tag FIFO. Writes push nothing (no return data).
- Return path: each mem_rdata_val beat gives rd_data=mem_rdata (combinational) and rd_val[head]=1. beat_cnt increments per beat. On the 8th beat (beat_cnt==7) the FIFO pops and beat_cnt wraps to 0.
- Simultaneous push and pop when full: pop frees the slot, but the push is still blocked that cycle. Eligibility uses the registered full flag.
- Simultaneous push and pop when empty is impossible, because data lags the command by at least tCAS.
- mem_rdata_val with FIFO empty: rd_val=0, err_orphan<=1 (cleared only by reset), beat_cnt unchanged.
- Reset mid-burst: FIFO and beat_cnt are flushed. Any remaining beats after reset release raise err_orphan.
- Widths: port index PORT_W=$clog2(NUM_PORTS). Pointer and FIFO indices wrap by power-of-2 or explicit compare; no overflow beyond TAG_DEPTH.

Optional Feature:
SDRAM_ARB_PRIO0_EN:
- Defined: port 0 has fixed highest priority. When port 0 is eligible it is granted regardless of rr_ptr. Ports 1..N-1 keep round-robin among themselves, and rr_ptr only advances on grants to ports 1..N-1.
- Undefined: pure round-robin across all ports as above.

Decomposition:
- Package sdram_arb_pkg:
  - ADDR_W=26, DATA_W=16, BURST_WORDS=8.
  - typedef sdram_addr_t: packed struct {chip, bank[1:0], row[12:0], col[9:0]}.
  - Function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module sdram_arb_tag_fifo: parameterised TAG_DEPTH x PORT_W, async reset, with push/pop/head/full/empty outputs.

Test Plan:
1. Single port, reset release, port 1 write addr 0x0000123 data 0xBEEF, mem_cmd_ready=1 -> same cycle req_ack=0010, mem_write=1, mem_addr=0x0000123; rr_ptr becomes 2.
2. All 4 ports hold writes, mem_cmd_ready=1 -> acks in order 0001, 0010, 0100, 1000, 0001 on consecutive cycles; mem_cmd_ready=0 for 3 cycles -> no acks, pointer frozen.
3. Port 2 read, then port 0 read; model returns 16 beats 0x0000..0x000F -> rd_val=0100 for beats 0-7, rd_val=0001 for beats 8-15; FIFO ends empty.
4. TAG_DEPTH=4: port 3 issues 5 reads with no data returned -> 4 acks, 5th held with req_ack=0 while port 1 write is still acked; after the first 8 beats return, the 5th read is acked.
5. Inject mem_rdata_val with FIFO empty -> rd_val=0, err_orphan=1 and stays 1 until reset; assert reset mid-burst -> all outputs 0 immediately (async).
6. With SDRAM_ARB_PRIO0_EN, ports 0 and 2 requesting continuously -> port 0 acked every cycle and port 2 starves; without the macro -> grants alternate 0, 2, 0, 2.
